// File: rtl/iter_fb_writer.sv
// Pixel sink for the shape iterators: range-checks (x, y, colr) pixels, turns them
// into linear framebuffer addresses and buffers them in a FIFO that drains under fb_grant.
module iter_fb_writer #(
  parameter int CORDW = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int COLRW = 4,
  parameter int ADDRW = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic [COLRW-1:0] colr,
  input  logic             drawing,
  output logic             oe,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [COLRW-1:0] fb_colr,
  input  logic             fb_grant,
  output logic             clipped,
  output logic             idle
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  localparam logic [CNTW-1:0]  FULL  = CNTW'(DEPTH);
  localparam logic [CORDW:0]   H_LIM = (CORDW+1)'(H_RES);
  localparam logic [CORDW:0]   V_LIM = (CORDW+1)'(V_RES);
  localparam logic [ADDRW-1:0] H_MUL = ADDRW'(H_RES);

  logic [ADDRW-1:0] addr_mem [DEPTH];
  logic [COLRW-1:0] colr_mem [DEPTH];

  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;

  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;
  logic [ADDRW-1:0] pix_addr;

  // Back-pressure depends only on registered occupancy, so there is no
  // combinational path from drawing or fb_grant back to the iterator.
  assign oe    = (count != FULL);
  assign fb_we = (count != '0);
  assign idle  = (count == '0);

  assign accept   = drawing && oe;
  assign in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  assign push     = accept && in_range;
  assign pop      = fb_we && fb_grant;

  // Every in-range address is below H_RES*V_RES <= 2^ADDRW, so arithmetic
  // modulo 2^ADDRW already yields the exact result.
  assign pix_addr = ADDRW'(y) * H_MUL + ADDRW'(x);

  assign fb_addr = addr_mem[rd_ptr];
  assign fb_colr = colr_mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count and the
  // pointers, so stale entries are never presented and a reset costs no extra flops.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= pix_addr;
      colr_mem[wr_ptr] <= colr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      clipped <= 1'b0;
    end else begin
      clipped <= accept && !in_range;
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_fb_writer.sv
// Directed self-checking bench for iter_fb_writer with hand-computed addresses
// for a 640x480 framebuffer and a 4-entry FIFO.
module tb_iter_fb_writer;

  localparam int CORDW = 10;
  localparam int ADDRW = 19;
  localparam int COLRW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic [COLRW-1:0] colr;
  logic             drawing;
  logic             oe;
  logic             fb_we;
  logic [ADDRW-1:0] fb_addr;
  logic [COLRW-1:0] fb_colr;
  logic             fb_grant;
  logic             clipped;
  logic             idle;

  int total = 0;
  int bad   = 0;
  int accepts = 0;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [COLRW-1:0] colr;
  } wr_t;

  wr_t obs[$];

  iter_fb_writer #(
    .CORDW(CORDW), .H_RES(640), .V_RES(480), .COLRW(COLRW), .ADDRW(ADDRW), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .colr(colr), .drawing(drawing),
    .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr),
    .fb_grant(fb_grant), .clipped(clipped), .idle(idle)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge, so the falling edge sees what the next edge will sample.
  always @(negedge clk) begin
    if (!rst && fb_we && fb_grant) obs.push_back('{addr: fb_addr, colr: fb_colr});
    if (!rst && drawing && oe) accepts++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a pixel and returns just after the edge that accepts it.
  task automatic send(input int px, input int py, input int pc);
    int guard = 0;
    x = CORDW'(px);
    y = CORDW'(py);
    colr = COLRW'(pc);
    drawing = 1'b1;
    while (!oe && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("send_timeout", 0, 1);
    step();
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (!idle && guard < 300) begin
      step();
      guard++;
    end
    check(tag, idle, 1);
  endtask

  initial begin
    rst = 1'b1;
    x = '0;
    y = '0;
    colr = '0;
    drawing = 1'b0;
    fb_grant = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_we", fb_we, 0);
    check("rst_idle", idle, 1);
    check("rst_oe", oe, 1);
    check("rst_clipped", clipped, 0);

    // Single pixel: (3,2) -> 2*640+3 = 1283
    obs.delete();
    fb_grant = 1'b1;
    send(3, 2, 5);
    drawing = 1'b0;
    check("single_we", fb_we, 1);
    check("single_addr", fb_addr, 1283);
    check("single_colr", fb_colr, 5);
    step();
    check("single_idle", idle, 1);
    check("single_we_after", fb_we, 0);
    check("single_n", obs.size(), 1);

    // Back-pressure: four accepts fill the FIFO, then oe drops
    obs.delete();
    accepts = 0;
    fb_grant = 1'b0;
    drawing = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = CORDW'(i);
      y = '0;
      colr = COLRW'(i);
      if (i == 3) check("bp_oe_at3", oe, 1);
      step();
    end
    check("bp_oe_full", oe, 0);
    check("bp_head", fb_addr, 0);
    x = 10'd4;
    colr = 4'd4;
    step();
    step();
    check("bp_oe_hold", oe, 0);
    check("bp_accepts", accepts, 4);
    fb_grant = 1'b1;
    for (int i = 4; i < 10; i++) send(i, 0, i);
    drawing = 1'b0;
    wait_idle("bp_drain");
    check("bp_n", obs.size(), 10);
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
      check($sformatf("bp_addr%0d", i), obs[i].addr, i);
      check($sformatf("bp_colr%0d", i), obs[i].colr, i);
    end

    // Clipping: only (639,479) -> 307199 is written
    obs.delete();
    fb_grant = 1'b1;
    send(640, 0, 1);
    check("clip_x", clipped, 1);
    send(0, 480, 2);
    check("clip_y", clipped, 1);
    send(639, 479, 7);
    check("clip_in", clipped, 0);
    drawing = 1'b0;
    step();
    check("clip_after", clipped, 0);
    wait_idle("clip_drain");
    check("clip_n", obs.size(), 1);
    if (obs.size() > 0) begin
      check("clip_addr", obs[0].addr, 307199);
      check("clip_colr", obs[0].colr, 7);
    end

    // Simultaneous push/pop at occupancy 2 over a 102-pixel row on y=5
    obs.delete();
    fb_grant = 1'b0;
    send(0, 5, 0);
    send(1, 5, 1);
    check("pp_we", fb_we, 1);
    check("pp_oe0", oe, 1);
    fb_grant = 1'b1;
    for (int i = 2; i < 102; i++) begin
      check($sformatf("pp_oe%0d", i), oe, 1);
      send(i, 5, i % 16);
      check($sformatf("pp_head%0d", i), fb_addr, 3200 + i - 1);
      check($sformatf("pp_busy%0d", i), idle, 0);
    end
    drawing = 1'b0;
    wait_idle("pp_drain");
    check("pp_n", obs.size(), 102);
    for (int i = 0; i < 102 && i < obs.size(); i++) begin
      check($sformatf("pp_addr%0d", i), obs[i].addr, 3200 + i);
      check($sformatf("pp_colr%0d", i), obs[i].colr, i % 16);
    end

    // Grant while empty: no pop, no underflow
    obs.delete();
    fb_grant = 1'b1;
    drawing = 1'b0;
    step();
    step();
    step();
    check("empty_we", fb_we, 0);
    check("empty_idle", idle, 1);
    check("empty_oe", oe, 1);
    check("empty_n", obs.size(), 0);

    // Reset mid-run discards buffered pixels
    obs.delete();
    fb_grant = 1'b0;
    send(10, 10, 1);
    send(11, 10, 2);
    send(12, 10, 3);
    drawing = 1'b0;
    check("mid_busy", idle, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_we", fb_we, 0);
    check("mid_idle", idle, 1);
    check("mid_oe", oe, 1);
    fb_grant = 1'b1;
    send(1, 1, 9);
    drawing = 1'b0;
    wait_idle("mid_drain");
    check("mid_n", obs.size(), 1);
    if (obs.size() > 0) begin
      check("mid_addr", obs[0].addr, 641);
      check("mid_colr", obs[0].colr, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
